// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: run/stop controller and double-buffered configuration front end
// for a programmable clock divider (period P, high time H, wrap tick).
module clk_div_ctrl #(
    parameter int unsigned W          = 8,
    parameter int unsigned DEF_PERIOD = 10,
    parameter int unsigned DEF_HIGH   = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         stop,
    input  logic         cfg_valid,
    input  logic [W-1:0] cfg_period,
    input  logic [W-1:0] cfg_high,
    output logic         cfg_ready,
    output logic         out,
    output logic         tick,
    output logic         busy,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] DEF_P_W   = W'(DEF_PERIOD);
    localparam logic [W-1:0] DEF_H_W   = W'(DEF_HIGH);
    localparam logic [W-1:0] MIN_P_W   = W'(2);
    localparam logic [W-1:0] ONE_W     = W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STOP = 2'd2
    } state_e;

    state_e       state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] per_q, per_d;
    logic [W-1:0] high_q, high_d;
    logic [W-1:0] sh_per_q, sh_per_d;
    logic [W-1:0] sh_high_q, sh_high_d;
    logic         sh_full_q, sh_full_d;

    logic         busy_c;
    logic         wrap_c;
    logic         xfer_c;
    logic [W-1:0] clamp_per_c;

    // Decode of the registered state; out/tick follow cnt with no extra delay
    assign busy_c      = (state_q != S_IDLE);
    assign wrap_c      = busy_c && (cnt_q == (per_q - ONE_W));
    assign xfer_c      = cfg_valid && !sh_full_q;
    assign clamp_per_c = (cfg_period < MIN_P_W) ? MIN_P_W : cfg_period;

    assign cfg_ready = !sh_full_q;
    assign busy      = busy_c;
    assign tick      = wrap_c;
    assign out       = busy_c && (cnt_q < high_q);
    assign cnt       = cnt_q;

    // Next-state: run/stop control, counting and shadow-to-active transfer
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        per_d     = per_q;
        high_d    = high_q;
        sh_per_d  = sh_per_q;
        sh_high_d = sh_high_q;
        sh_full_d = sh_full_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start && !stop) state_d = S_RUN;
            end
            S_RUN: begin
                cnt_d = wrap_c ? '0 : cnt_q + ONE_W;
                if (stop) state_d = wrap_c ? S_IDLE : S_STOP;
            end
            S_STOP: begin
                cnt_d = wrap_c ? '0 : cnt_q + ONE_W;
                if (start)       state_d = S_RUN;
                else if (wrap_c) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Settings change only while idle or on a period boundary
        if (sh_full_q && (!busy_c || wrap_c)) begin
            per_d     = sh_per_q;
            high_d    = sh_high_q;
            sh_full_d = 1'b0;
        end

        // Capture only into an empty shadow, so never collides with the copy above
        if (xfer_c) begin
            sh_per_d  = clamp_per_c;
            sh_high_d = cfg_high;
            sh_full_d = 1'b1;
        end
    end

    // State and configuration registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            per_q     <= DEF_P_W;
            high_q    <= DEF_H_W;
            sh_per_q  <= DEF_P_W;
            sh_high_q <= DEF_H_W;
            sh_full_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            per_q     <= per_d;
            high_q    <= high_d;
            sh_per_q  <= sh_per_d;
            sh_high_q <= sh_high_d;
            sh_full_q <= sh_full_d;
        end
    end

endmodule
